// File: rtl/stopwatch_pkg.sv
// Shared types and BCD field arithmetic for the stopwatch core.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } field_t;

  // Result of a single field step: new value plus carry (inc) or borrow (dec).
  typedef struct packed {
    field_t value;
    logic   carry;
  } field_res_t;

  localparam int SEC_RADIX = 60;

  function automatic logic [6:0] field_to_bin(field_t f);
    return ({3'b000, f.tens} * 7'd10) + {3'b000, f.ones};
  endfunction

  function automatic field_t bin_to_field(logic [6:0] b);
    field_t f;
    f.tens = 4'(b / 7'd10);
    f.ones = 4'(b % 7'd10);
    return f;
  endfunction

  // Increment modulo (fmax+1); anything at or above fmax wraps so digits stay legal.
  function automatic field_res_t field_inc(field_t v, logic [6:0] fmax);
    field_res_t r;
    logic [6:0] b;
    b = field_to_bin(v);
    if (b >= fmax) begin
      r.value = '0;
      r.carry = 1'b1;
    end else begin
      r.value = bin_to_field(b + 7'd1);
      r.carry = 1'b0;
    end
    return r;
  endfunction

  // Decrement with borrow: 0 -> fmax.
  function automatic field_res_t field_dec(field_t v, logic [6:0] fmax);
    field_res_t r;
    logic [6:0] b;
    b = field_to_bin(v);
    if (b == 7'd0) begin
      r.value = bin_to_field(fmax);
      r.carry = 1'b1;
    end else if (b > fmax) begin
      r.value = bin_to_field(fmax);
      r.carry = 1'b0;
    end else begin
      r.value = bin_to_field(b - 7'd1);
      r.carry = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_core_n_if.sv
// Control/display bundle between the pulse sources, the core and the scan mux.
interface stopwatch_core_n_if #(
  parameter int NUM_FIELDS = 2
);
  localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

  logic                    tick_cnt;
  logic                    tick_adj;
  logic                    pause_pulse;
  logic                    lap_pulse;
  logic                    clear_pulse;
  logic                    adj_en;
  logic [SEL_W-1:0]        adj_sel;
  logic                    mode_down;
  logic [8*NUM_FIELDS-1:0] digits;
  logic [8*NUM_FIELDS-1:0] lap_digits;
  logic                    lap_valid;
  logic                    running;
  logic                    expired;

  // Pulse/level source side.
  modport master (
    output tick_cnt, tick_adj, pause_pulse, lap_pulse, clear_pulse,
    output adj_en, adj_sel, mode_down,
    input  digits, lap_digits, lap_valid, running, expired
  );

  // Stopwatch core side.
  modport slave (
    input  tick_cnt, tick_adj, pause_pulse, lap_pulse, clear_pulse,
    input  adj_en, adj_sel, mode_down,
    output digits, lap_digits, lap_valid, running, expired
  );
endinterface

// File: rtl/bcd_field_counter.sv
// One two-digit BCD field with count up/down, adjust step and clear.
module bcd_field_counter
  import stopwatch_pkg::*;
#(
  parameter int FIELD_MAX = 59
) (
  input  logic   clk_100mhz,
  input  logic   rst_n,
  input  logic   inc_i,
  input  logic   dec_i,
  input  logic   adj_inc_i,
  input  logic   clr_i,
  output field_t value_o,
  output logic   carry_o,
  output logic   borrow_o,
  output logic   at_max_o,
  output logic   at_zero_o
);
  localparam logic [6:0] MAX_B = 7'(FIELD_MAX);

  field_t     val_q, val_d;
  field_res_t up_r, dn_r;

  // Next value: clear wins, then adjust/count-up, then count-down.
  always_comb begin
    up_r  = field_inc(val_q, MAX_B);
    dn_r  = field_dec(val_q, MAX_B);
    val_d = val_q;
    if (clr_i)                  val_d = '0;
    else if (adj_inc_i || inc_i) val_d = up_r.value;
    else if (dec_i)             val_d = dn_r.value;
  end

  // Field value register.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign value_o   = val_q;
  assign carry_o   = inc_i && up_r.carry;
  assign borrow_o  = dec_i && dn_r.carry;
  assign at_max_o  = (field_to_bin(val_q) >= MAX_B);
  assign at_zero_o = (val_q == '0);
endmodule

// File: rtl/stopwatch_core_n.sv
// N-field BCD stopwatch / countdown timer with lap capture and field adjust.
module stopwatch_core_n
  import stopwatch_pkg::*;
#(
  parameter int NUM_FIELDS   = 2,
  parameter int TOP_MAX      = 99,
  parameter int SAT_UP       = 0,
  parameter int RUN_ON_RESET = 1
) (
  input logic               clk_100mhz,
  input logic               rst_n,
  stopwatch_core_n_if.slave bus
);
  localparam int   SEL_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam logic RUN_RST = (RUN_ON_RESET != 0);
  localparam logic SAT_EN  = (SAT_UP != 0);

  field_t [NUM_FIELDS-1:0] val;
  logic   [NUM_FIELDS-1:0] at_max, at_zero, one_vec;

  logic count_en, up_tick, dn_tick, adj_go;
  logic all_max, all_zero, one_left;
  logic inc0, dec0, sat_hit, dn_expire;

  logic                    run_q, run_d;
  logic                    exp_q, exp_d;
  logic                    lapv_q, lapv_d;
  logic [8*NUM_FIELDS-1:0] lap_q, lap_d;

  // Counting needs the pre-toggle run flag; clear and adjust both mask it.
  assign count_en = bus.tick_cnt && run_q && !bus.adj_en && !bus.clear_pulse;
  assign up_tick  = count_en && !bus.mode_down;
  assign dn_tick  = count_en &&  bus.mode_down;
  assign adj_go   = bus.adj_en && bus.tick_adj && !bus.clear_pulse;

  assign all_max  = &at_max;
  assign all_zero = &at_zero;
  assign one_left = &one_vec;

  // Saturating up-count holds at all-max; down-count holds at zero.
  assign sat_hit   = up_tick && SAT_EN && all_max;
  assign inc0      = up_tick && !sat_hit;
  assign dec0      = dn_tick && !all_zero;
  assign dn_expire = dn_tick && (all_zero || one_left);

  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
    localparam int FMAX = (i == NUM_FIELDS - 1) ? TOP_MAX : SEC_RADIX - 1;
    logic inc, dec, adj, cy, bw;

    assign adj = adj_go && (bus.adj_sel == SEL_W'(i));

    if (i == 0) begin : g_lsb
      assign inc        = inc0;
      assign dec        = dec0;
      assign one_vec[i] = (val[i] == field_t'(8'h01));
    end else begin : g_chain
      assign inc        = g_field[i-1].cy;
      assign dec        = g_field[i-1].bw;
      assign one_vec[i] = at_zero[i];
    end

    bcd_field_counter #(.FIELD_MAX(FMAX)) u_fld (
      .clk_100mhz (clk_100mhz),
      .rst_n      (rst_n),
      .inc_i      (inc),
      .dec_i      (dec),
      .adj_inc_i  (adj),
      .clr_i      (bus.clear_pulse),
      .value_o    (val[i]),
      .carry_o    (cy),
      .borrow_o   (bw),
      .at_max_o   (at_max[i]),
      .at_zero_o  (at_zero[i])
    );
  end

  // Carry/borrow out of the top field has nowhere to go (wrap is implicit).
  logic unused_chain;
  assign unused_chain = g_field[NUM_FIELDS-1].cy ^ g_field[NUM_FIELDS-1].bw;

  // Run flag, sticky expiry and lap register next-state.
  always_comb begin
    run_d  = run_q;
    exp_d  = exp_q;
    lap_d  = lap_q;
    lapv_d = lapv_q;
    if (bus.clear_pulse) begin
      run_d  = RUN_RST;
      exp_d  = 1'b0;
      lap_d  = '0;
      lapv_d = 1'b0;
    end else begin
      if (bus.pause_pulse) run_d = !run_q;
      if (bus.lap_pulse) begin
        lap_d  = val;
        lapv_d = 1'b1;
      end
      // Expiry stops the clock even if a pause toggled it this cycle.
      if (sat_hit || dn_expire) begin
        exp_d = 1'b1;
        run_d = 1'b0;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= RUN_RST;
      exp_q  <= 1'b0;
      lap_q  <= '0;
      lapv_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      exp_q  <= exp_d;
      lap_q  <= lap_d;
      lapv_q <= lapv_d;
    end
  end

  assign bus.digits     = val;
  assign bus.lap_digits = lap_q;
  assign bus.lap_valid  = lapv_q;
  assign bus.running    = run_q;
  assign bus.expired    = exp_q;
endmodule

// File: tb/tb_stopwatch_core_n.sv
// Randomised + directed bench for stopwatch_core_n against a seconds-count model.
module tb_stopwatch_core_n;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stopwatch_core_n_if #(.NUM_FIELDS(2)) bus ();

  stopwatch_core_n #(
    .NUM_FIELDS(2), .TOP_MAX(99), .SAT_UP(0), .RUN_ON_RESET(1)
  ) dut (
    .clk_100mhz (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  // Model state: whole time kept as total seconds (MM*60 + SS).
  typedef struct {
    int total;
    bit run;
    bit exp;
    int lap;
    bit lapv;
  } mstate_t;

  localparam int MODV = 100 * 60;
  localparam mstate_t RST_STATE = '{total: 0, run: 1'b1, exp: 1'b0, lap: 0, lapv: 1'b0};

  mstate_t ms;

  function automatic logic [15:0] pack(int t);
    int s, m;
    s = t % 60;
    m = t / 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic mstate_t model_next(mstate_t s, bit tc, bit ta, bit pp, bit lp,
                                         bit cp, bit ae, bit sel, bit dn);
    mstate_t n = s;
    int sec, mn;
    if (cp) return RST_STATE;
    if (pp) n.run = !s.run;
    if (lp) begin
      n.lap  = s.total;
      n.lapv = 1'b1;
    end
    if (ae) begin
      if (ta) begin
        sec = s.total % 60;
        mn  = s.total / 60;
        if (sel == 1'b0) sec = (sec + 1) % 60;
        else             mn  = (mn + 1) % 100;
        n.total = mn * 60 + sec;
      end
    end else if (tc && s.run) begin
      if (!dn) n.total = (s.total + 1) % MODV;
      else begin
        if (s.total > 0) n.total = s.total - 1;
        if (n.total == 0) begin
          n.exp = 1'b1;
          n.run = 1'b0;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= RST_STATE;
    else ms <= model_next(ms, bus.tick_cnt, bus.tick_adj, bus.pause_pulse, bus.lap_pulse,
                          bus.clear_pulse, bus.adj_en, bus.adj_sel[0], bus.mode_down);
  end

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk16("digits", bus.digits, pack(ms.total));
      chk16("lap_digits", bus.lap_digits, pack(ms.lap));
      chkb("lap_valid", bus.lap_valid, ms.lapv);
      chkb("running", bus.running, ms.run);
      chkb("expired", bus.expired, ms.exp);
    end
  end

  // One cycle of pulses, starting and ending on a falling edge.
  task automatic step(input bit tc = 1'b0, input bit ta = 1'b0, input bit pp = 1'b0,
                      input bit lp = 1'b0, input bit cp = 1'b0);
    bus.tick_cnt    = tc;
    bus.tick_adj    = ta;
    bus.pause_pulse = pp;
    bus.lap_pulse   = lp;
    bus.clear_pulse = cp;
    @(negedge clk);
    bus.tick_cnt    = 1'b0;
    bus.tick_adj    = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.lap_pulse   = 1'b0;
    bus.clear_pulse = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.tick_cnt    = 1'b0;
    bus.tick_adj    = 1'b0;
    bus.pause_pulse = 1'b0;
    bus.lap_pulse   = 1'b0;
    bus.clear_pulse = 1'b0;
    bus.adj_en      = 1'b0;
    bus.adj_sel     = 1'b0;
    bus.mode_down   = 1'b0;
    repeat (2) @(negedge clk);
    chk16("rst_digits", bus.digits, 16'h0000);
    chkb("rst_running", bus.running, 1'b1);
    chkb("rst_expired", bus.expired, 1'b0);
    chkb("rst_lap_valid", bus.lap_valid, 1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // 1: up count with carry, then wrap from 99:59.
    repeat (61) step(.tc(1'b1));
    chk16("t1_0101", bus.digits, 16'h0101);
    bus.adj_en  = 1'b1;
    bus.adj_sel = 1'b0;
    repeat (58) step(.ta(1'b1));
    bus.adj_sel = 1'b1;
    repeat (98) step(.ta(1'b1));
    chk16("t1_preset", bus.digits, 16'h9959);
    bus.adj_en = 1'b0;
    step(.tc(1'b1));
    chk16("t1_wrap", bus.digits, 16'h0000);
    chkb("t1_expired", bus.expired, 1'b0);

    // 2: pause during adjust persists; seconds adjust wraps without carry.
    repeat (5) step(.tc(1'b1));
    chk16("t2_0005", bus.digits, 16'h0005);
    bus.adj_en = 1'b1;
    step(.pp(1'b1));
    bus.adj_sel = 1'b0;
    repeat (57) step(.ta(1'b1));
    step(.tc(1'b1));
    chk16("t2_tick_ignored_in_adj", bus.digits, 16'h0002);
    bus.adj_en = 1'b0;
    repeat (10) step(.tc(1'b1));
    chk16("t2_frozen", bus.digits, 16'h0002);
    chkb("t2_running", bus.running, 1'b0);

    // 3: countdown to expiry, hold at zero, pause re-arms then next tick stops.
    step(.pp(1'b1));
    step(.tc(1'b1));
    chk16("t3_0003", bus.digits, 16'h0003);
    bus.mode_down = 1'b1;
    repeat (3) step(.tc(1'b1));
    chk16("t3_zero", bus.digits, 16'h0000);
    chkb("t3_expired", bus.expired, 1'b1);
    chkb("t3_stopped", bus.running, 1'b0);
    repeat (2) step(.tc(1'b1));
    step(.pp(1'b1));
    chkb("t3_rerun", bus.running, 1'b1);
    chk16("t3_hold", bus.digits, 16'h0000);
    step(.tc(1'b1));
    chkb("t3_restop", bus.running, 1'b0);
    chkb("t3_sticky", bus.expired, 1'b1);
    step(.cp(1'b1));
    chkb("t3_clr_exp", bus.expired, 1'b0);
    bus.mode_down = 1'b0;

    // 4: lap together with a count captures the old value.
    repeat (9) step(.tc(1'b1));
    step(.tc(1'b1), .lp(1'b1));
    chk16("t4_lap", bus.lap_digits, 16'h0009);
    chkb("t4_lapv", bus.lap_valid, 1'b1);
    chk16("t4_digits", bus.digits, 16'h0010);

    // 5: clear beats pause and tick in the same cycle.
    repeat (32) step(.tc(1'b1));
    chk16("t5_0042", bus.digits, 16'h0042);
    step(.tc(1'b1), .pp(1'b1), .cp(1'b1));
    chk16("t5_digits", bus.digits, 16'h0000);
    chkb("t5_running", bus.running, 1'b1);
    chkb("t5_lapv", bus.lap_valid, 1'b0);

    // 6: asynchronous reset between edges.
    bus.adj_en  = 1'b1;
    bus.adj_sel = 1'b1;
    repeat (12) step(.ta(1'b1));
    bus.adj_sel = 1'b0;
    repeat (34) step(.ta(1'b1));
    bus.adj_en = 1'b0;
    step(.lp(1'b1));
    chk16("t6_1234", bus.digits, 16'h1234);
    #1 rst_n = 1'b0;
    #1;
    chk16("t6_async_digits", bus.digits, 16'h0000);
    chk16("t6_async_lap", bus.lap_digits, 16'h0000);
    chkb("t6_async_lapv", bus.lap_valid, 1'b0);
    chkb("t6_async_run", bus.running, 1'b1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    repeat (5) step(.tc(1'b1));
    chk16("t6_resume", bus.digits, 16'h0005);

    // Random phase: model compare runs every cycle.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(19) == 0) bus.adj_en = !bus.adj_en;
      if ($urandom_range(39) == 0) bus.mode_down = !bus.mode_down;
      bus.adj_sel = 1'($urandom_range(1));
      step(.tc(1'($urandom_range(1))), .ta($urandom_range(2) == 0),
           .pp($urandom_range(15) == 0), .lp($urandom_range(15) == 0),
           .cp($urandom_range(63) == 0));
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
